// File: rtl/vend_pkg.sv
// Shared types for the vending slot controller: FSM state encoding, coin
// encodings and the coin-to-credit conversion used by the top level.
package vend_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DISPENSE = 2'd1,
      ST_CHANGE   = 2'd2,
      ST_FAULT    = 2'd3
   } state_t;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;
   localparam logic [1:0] COIN_BAD  = 2'b11;

   // Credit value of a coin in Rs5 units; invalid/no coin is worth nothing.
   function automatic logic [1:0] coin_value(input logic [1:0] coin);
      case (coin)
         COIN_5:  coin_value = 2'd1;
         COIN_10: coin_value = 2'd2;
         default: coin_value = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-slot stock counters with bulk refill, single-slot decrement and an
// empty flag for the slot currently being checked.
module vend_stock_bank #(
   parameter int NUM_SLOTS  = 4,
   parameter int SEL_W      = 2,
   parameter int STOCK_W    = 3,
   parameter int STOCK_INIT = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             refill,
   input  logic             dec,
   input  logic [SEL_W-1:0] dec_idx,
   input  logic [SEL_W-1:0] chk_idx,
   output logic             empty
);

   localparam logic [STOCK_W-1:0] INIT_V = STOCK_W'(STOCK_INIT);

   logic [STOCK_W-1:0] stock [NUM_SLOTS];

   // The zero guard keeps a slot from wrapping even if dec is misused.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_SLOTS; i++) stock[i] <= INIT_V;
      end else if (refill) begin
         for (int i = 0; i < NUM_SLOTS; i++) stock[i] <= INIT_V;
      end else if (dec && (stock[dec_idx] != '0)) begin
         stock[dec_idx] <= stock[dec_idx] - 1'b1;
      end
   end

   assign empty = (stock[chk_idx] == '0);

endmodule

// File: rtl/vend_slot_controller.sv
// Multi-slot vending sequencer: coin credit, selection checks, dispenser
// handshake and Rs5 change payout. Optional watchdog via VEND_TIMEOUT_EN.
module vend_slot_controller
   import vend_pkg::*;
#(
   parameter int NUM_SLOTS  = 4,
   parameter int SEL_W      = 2,
   parameter int PRICE      = 3,
   parameter int MAX_CREDIT = 8,
   parameter int CRED_W     = 4,
   parameter int STOCK_INIT = 7,
   parameter int STOCK_W    = 3
`ifdef VEND_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = 255
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        coin,
   input  logic              sel_valid,
   input  logic [SEL_W-1:0]  sel_id,
   input  logic              cancel,
   input  logic              refill,
   input  logic              disp_ack,
   output logic              disp_req,
   output logic [SEL_W-1:0]  disp_id,
   output logic              vend_done,
   output logic              change_pulse,
   output logic              coin_reject,
   output logic              sold_out,
   output logic [CRED_W-1:0] credit,
   output logic              busy
`ifdef VEND_TIMEOUT_EN
   , output logic            fault
`endif
);

   localparam logic [CRED_W-1:0] PRICE_C = CRED_W'(PRICE);
   localparam logic [CRED_W:0]   MAX_C   = (CRED_W+1)'(MAX_CREDIT);

   state_t             state, state_n, done_state;
   logic [CRED_W-1:0]  credit_n, credit_left;
   logic [CRED_W:0]    credit_sum;
   logic [SEL_W-1:0]   disp_id_n;
   logic               vend_done_n, change_pulse_n, coin_reject_n, sold_out_n;
   logic               sel_take, stock_dec, refill_en, slot_empty;

`ifdef VEND_TIMEOUT_EN
   localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             fault_pend, fault_pend_n;
`endif

   vend_stock_bank #(
      .NUM_SLOTS  (NUM_SLOTS),
      .SEL_W      (SEL_W),
      .STOCK_W    (STOCK_W),
      .STOCK_INIT (STOCK_INIT)
   ) u_stock (
      .clk     (clk),
      .rst     (rst),
      .refill  (refill_en),
      .dec     (stock_dec),
      .dec_idx (disp_id),
      .chk_idx (sel_id),
      .empty   (slot_empty)
   );

   assign credit_sum  = {1'b0, credit} + {{(CRED_W-1){1'b0}}, coin_value(coin)};
   assign credit_left = credit - PRICE_C;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         credit       <= '0;
         disp_id      <= '0;
         vend_done    <= 1'b0;
         change_pulse <= 1'b0;
         coin_reject  <= 1'b0;
         sold_out     <= 1'b0;
      end else begin
         state        <= state_n;
         credit       <= credit_n;
         disp_id      <= disp_id_n;
         vend_done    <= vend_done_n;
         change_pulse <= change_pulse_n;
         coin_reject  <= coin_reject_n;
         sold_out     <= sold_out_n;
      end
   end

`ifdef VEND_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= '0;
         fault_pend <= 1'b0;
      end else begin
         cnt        <= cnt_n;
         fault_pend <= fault_pend_n;
      end
   end

   assign done_state = fault_pend ? ST_FAULT : ST_IDLE;
   assign fault      = (state == ST_FAULT);
`else
   assign done_state = ST_IDLE;
`endif

   always_comb begin
      state_n        = state;
      credit_n       = credit;
      disp_id_n      = disp_id;
      vend_done_n    = 1'b0;
      change_pulse_n = 1'b0;
      coin_reject_n  = 1'b0;
      sold_out_n     = 1'b0;
      sel_take       = 1'b0;
      stock_dec      = 1'b0;
      refill_en      = 1'b0;
`ifdef VEND_TIMEOUT_EN
      cnt_n          = cnt;
      fault_pend_n   = fault_pend;
`endif
      case (state)
         ST_IDLE: begin
            refill_en = refill;
            // A cancel with no credit is fully ignored, so selection and coin still apply.
            if (cancel && (credit != '0)) begin
               state_n       = ST_CHANGE;
               coin_reject_n = (coin != COIN_NONE);
            end else begin
               if (sel_valid) begin
                  if (slot_empty) begin
                     sold_out_n = 1'b1;
                  end else if (credit >= PRICE_C) begin
                     sel_take  = 1'b1;
                     disp_id_n = sel_id;
                     state_n   = ST_DISPENSE;
`ifdef VEND_TIMEOUT_EN
                     cnt_n     = '0;
`endif
                  end
               end
               if (coin != COIN_NONE) begin
                  if ((coin == COIN_BAD) || sel_take || (credit_sum > MAX_C)) begin
                     coin_reject_n = 1'b1;
                  end else begin
                     credit_n = credit_sum[CRED_W-1:0];
                  end
               end
            end
         end
         ST_DISPENSE: begin
            coin_reject_n = (coin != COIN_NONE);
            if (disp_ack) begin
               stock_dec   = 1'b1;
               credit_n    = credit_left;
               vend_done_n = 1'b1;
               state_n     = (credit_left != '0) ? ST_CHANGE : ST_IDLE;
            end
`ifdef VEND_TIMEOUT_EN
            else if (cnt == CNT_LAST) begin
               fault_pend_n = 1'b1;
               state_n      = (credit != '0) ? ST_CHANGE : ST_FAULT;
            end else begin
               cnt_n = cnt + 1'b1;
            end
`endif
         end
         ST_CHANGE: begin
            coin_reject_n = (coin != COIN_NONE);
            if (credit != '0) begin
               change_pulse_n = 1'b1;
               credit_n       = credit - 1'b1;
               if (credit == CRED_W'(1)) state_n = done_state;
            end else begin
               state_n = done_state;
            end
         end
         ST_FAULT: begin
            coin_reject_n = (coin != COIN_NONE);
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign disp_req = (state == ST_DISPENSE);
   assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_vend_slot_controller.sv
// Self-checking bench for vend_slot_controller: directed scenarios plus random
// traffic, all compared cycle by cycle against a behavioural vending model.
module tb_vend_slot_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] coin = 2'b00;
   logic       sel_valid = 1'b0;
   logic [1:0] sel_id = 2'b00;
   logic       cancel = 1'b0;
   logic       refill = 1'b0;
   logic       disp_ack = 1'b0;
   logic       disp_req, vend_done, change_pulse, coin_reject, sold_out, busy;
   logic [1:0] disp_id;
   logic [3:0] credit;
`ifdef VEND_TIMEOUT_EN
   logic       fault;
`endif

   int n_vec  = 0;
   int n_fail = 0;

   // Behavioural model: money in Rs5 units, stock per slot, and what the machine is doing.
   int m_credit;
   int m_stock [4];
   int m_slot;
   bit m_dispensing, m_paying;
   bit m_done, m_chg, m_rej, m_sold;

   vend_slot_controller dut (
      .clk          (clk),
      .rst          (rst),
      .coin         (coin),
      .sel_valid    (sel_valid),
      .sel_id       (sel_id),
      .cancel       (cancel),
      .refill       (refill),
      .disp_ack     (disp_ack),
      .disp_req     (disp_req),
      .disp_id      (disp_id),
      .vend_done    (vend_done),
      .change_pulse (change_pulse),
      .coin_reject  (coin_reject),
      .sold_out     (sold_out),
      .credit       (credit),
      .busy         (busy)
`ifdef VEND_TIMEOUT_EN
      , .fault      (fault)
`endif
   );

   always #5 clk = ~clk;

   task automatic modelReset();
      m_credit = 0;
      for (int i = 0; i < 4; i++) m_stock[i] = 7;
      m_slot = 0;
      m_dispensing = 0;
      m_paying = 0;
      m_done = 0; m_chg = 0; m_rej = 0; m_sold = 0;
   endtask

   task automatic modelStep();
      int  v;
      bit  took;
      m_done = 0; m_chg = 0; m_rej = 0; m_sold = 0;
      v = (coin == 2'b01) ? 1 : (coin == 2'b10) ? 2 : 0;
      if (m_dispensing) begin
         m_rej = (coin != 2'b00);
         if (disp_ack) begin
            m_stock[m_slot] -= 1;
            m_credit -= 3;
            m_done = 1;
            m_dispensing = 0;
            m_paying = (m_credit > 0);
         end
      end else if (m_paying) begin
         m_rej = (coin != 2'b00);
         m_credit -= 1;
         m_chg = 1;
         if (m_credit == 0) m_paying = 0;
      end else begin
         took = 0;
         if (cancel && m_credit > 0) begin
            m_paying = 1;
            m_rej = (coin != 2'b00);
         end else begin
            if (sel_valid) begin
               if (m_stock[sel_id] == 0) m_sold = 1;
               else if (m_credit >= 3) begin
                  took = 1;
                  m_dispensing = 1;
                  m_slot = int'(sel_id);
               end
            end
            if (coin != 2'b00) begin
               if (coin == 2'b11 || took || m_credit + v > 8) m_rej = 1;
               else m_credit += v;
            end
         end
         if (refill) for (int i = 0; i < 4; i++) m_stock[i] = 7;
      end
   endtask

   task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      checkOne("disp_req", disp_req, m_dispensing);
      checkOne("vend_done", vend_done, m_done);
      checkOne("change_pulse", change_pulse, m_chg);
      checkOne("coin_reject", coin_reject, m_rej);
      checkOne("sold_out", sold_out, m_sold);
      checkOne("credit", credit, m_credit);
      checkOne("busy", busy, m_dispensing | m_paying);
      if (m_dispensing) checkOne("disp_id", disp_id, m_slot);
   endtask

   task automatic applyStimulus(input logic [1:0] c, input bit sv, input logic [1:0] sid,
                                input bit can, input bit rf, input bit ack);
      coin = c; sel_valid = sv; sel_id = sid; cancel = can; refill = rf; disp_ack = ack;
      @(posedge clk);
      modelStep();
      #1;
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(2'b00, 0, 2'd0, 0, 0, 0);
   endtask

   task automatic buyFifteen(input logic [1:0] slot);
      applyStimulus(2'b10, 0, 2'd0, 0, 0, 0);
      applyStimulus(2'b01, 0, 2'd0, 0, 0, 0);
      applyStimulus(2'b00, 1, slot, 0, 0, 0);
   endtask

`ifdef VEND_TIMEOUT_EN
   task automatic tick(input logic [1:0] c);
      coin = c; sel_valid = 0; cancel = 0; refill = 0; disp_ack = 0;
      @(posedge clk);
      #1;
   endtask
`endif

   initial begin
      int pulses;
      logic [1:0] rc, rs;
      int r;

      modelReset();
      #12;
      checkOutput();
      rst = 1'b1;

      // Rs10 + Rs5, select slot 2, then acknowledge
      buyFifteen(2'd2);
      checkOne("t1_disp_req", disp_req, 1);
      checkOne("t1_disp_id", disp_id, 2);
      applyStimulus(2'b00, 0, 2'd0, 0, 0, 1);
      checkOne("t1_vend_done", vend_done, 1);
      checkOne("t1_credit", credit, 0);
      checkOne("t1_busy", busy, 0);

      // Rs10 x2, select slot 0, exactly one change coin afterwards
      applyStimulus(2'b10, 0, 2'd0, 0, 0, 0);
      applyStimulus(2'b10, 0, 2'd0, 0, 0, 0);
      applyStimulus(2'b00, 1, 2'd0, 0, 0, 0);
      applyStimulus(2'b00, 0, 2'd0, 0, 0, 1);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         idle(1);
         pulses += int'(change_pulse);
      end
      checkOne("t2_pulses", pulses, 1);
      checkOne("t2_credit", credit, 0);

      // Fill to the ceiling, overflow coin rejected, cancel refunds everything
      for (int i = 0; i < 4; i++) applyStimulus(2'b10, 0, 2'd0, 0, 0, 0);
      checkOne("t3_credit_max", credit, 8);
      applyStimulus(2'b01, 0, 2'd0, 0, 0, 0);
      checkOne("t3_reject", coin_reject, 1);
      checkOne("t3_credit_hold", credit, 8);
      applyStimulus(2'b00, 0, 2'd0, 1, 0, 0);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         idle(1);
         pulses += int'(change_pulse);
      end
      checkOne("t3_pulses", pulses, 8);

      // Drain slot 1, then selection of the empty slot is refused
      for (int k = 0; k < 7; k++) begin
         buyFifteen(2'd1);
         applyStimulus(2'b00, 0, 2'd0, 0, 0, 1);
      end
      buyFifteen(2'd1);
      checkOne("t4_sold_out", sold_out, 1);
      checkOne("t4_credit", credit, 3);
      checkOne("t4_no_req", disp_req, 0);
      applyStimulus(2'b00, 0, 2'd0, 0, 1, 0);
      applyStimulus(2'b00, 1, 2'd1, 0, 0, 0);
      checkOne("t4_refill_req", disp_req, 1);
      applyStimulus(2'b00, 0, 2'd0, 0, 0, 1);

      // Coin during dispense, then async reset mid-dispense
      buyFifteen(2'd3);
      applyStimulus(2'b10, 0, 2'd0, 0, 0, 0);
      checkOne("t5_reject_disp", coin_reject, 1);
      checkOne("t5_credit_disp", credit, 3);
      #2 rst = 1'b0;
      #1;
      modelReset();
      checkOne("t5_rst_req", disp_req, 0);
      checkOne("t5_rst_credit", credit, 0);
      checkOne("t5_rst_busy", busy, 0);
      #3 rst = 1'b1;
      applyStimulus(2'b01, 0, 2'd0, 0, 0, 0);
      applyStimulus(2'b11, 0, 2'd0, 0, 0, 0);
      checkOne("t5_bad_coin", coin_reject, 1);
      checkOne("t5_bad_credit", credit, 1);

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         r  = int'($urandom_range(0, 9));
         rc = (r < 6) ? 2'b00 : 2'(r - 6);
         rs = 2'($urandom_range(0, 3));
         applyStimulus(rc, $urandom_range(0, 3) == 0, rs, $urandom_range(0, 19) == 0,
                       $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
      end

`ifdef VEND_TIMEOUT_EN
      // Watchdog: no acknowledge ever arrives
      rst = 1'b0;
      #3 rst = 1'b1;
      modelReset();
      buyFifteen(2'd0);
      r = 0;
      while (disp_req === 1'b1 && r < 300) begin
         tick(2'b00);
         r++;
      end
      checkOne("to_cycles", r, 255);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         tick(2'b00);
         pulses += int'(change_pulse);
      end
      checkOne("to_pulses", pulses, 3);
      checkOne("to_fault", fault, 1);
      tick(2'b01);
      checkOne("to_reject", coin_reject, 1);
      checkOne("to_credit", credit, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
